// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package disp_pkg;
  localparam int         NUM_DIGITS = 4;
  localparam int         IDX_W      = 2;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  typedef enum logic { BLANK, SHOW } state_e;

  typedef struct packed {
    logic [15:0] num;
    logic [3:0]  pts;
    logic [3:0]  en;
  } disp_buf_t;

  function automatic logic [3:0] an_sel(input logic [IDX_W-1:0] idx);
    return ~(4'b0001 << idx);
  endfunction
endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Value/strobe inputs from register logic and decoder/anode outputs to the board.
interface disp_scan_ctrl_if;
  logic [15:0] disp_num;
  logic [3:0]  points;
  logic [3:0]  digit_en;
  logic        load;
  logic [3:0]  AN;
  logic [3:0]  D;
  logic        LE;
  logic        point;
  logic        frame_done;

  modport master (output disp_num, points, digit_en, load,
                  input  AN, D, LE, point, frame_done);
  modport slave  (input  disp_num, points, digit_en, load,
                  output AN, D, LE, point, frame_done);
endinterface

// File: rtl/disp_slot_timer.sv
// Per-digit slot counter and digit index, with blank/slot/frame end strobes.
module disp_slot_timer
  import disp_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] idx_next,
  output logic             blank_end,
  output logic             slot_end,
  output logic             frame_end
);
  localparam int               CNT_W      = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Strobes fire on the last cycle of their phase so the next edge lands on the boundary.
  always_comb begin
    blank_end = (cnt_q == BLANK_LAST);
    slot_end  = (cnt_q == SLOT_LAST);
    frame_end = slot_end && (idx_q == '1);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    idx_d     = slot_end ? idx_q + 1'b1 : idx_q;
    idx_next  = idx_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit scan controller driving one shared hex decoder with double-buffered content.
// Define DISP_SCAN_LZB_EN to blank leading zero digits (digit 0 always shown).
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  disp_scan_ctrl_if.slave  bus
);
  logic [IDX_W-1:0] idx_next;
  logic             blank_end, slot_end, frame_end;

  disp_slot_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .idx_next  (idx_next),
    .blank_end (blank_end),
    .slot_end  (slot_end),
    .frame_end (frame_end)
  );

  state_e    state_q, state_d;
  disp_buf_t act_q, act_d, pend_q, pend_d;
  logic      pend_v_q, pend_v_d;
  logic [3:0] an_q, an_d, d_q, d_d;
  logic       le_q, le_d, point_q, point_d, fd_q, fd_d;
  logic [NUM_DIGITS-1:0] eff_en;
  logic       show;

  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK:   if (blank_end) state_d = SHOW;
      SHOW:    if (slot_end)  state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  // A load coinciding with the frame edge lands in pending and waits a full frame.
  always_comb begin
    act_d    = act_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (frame_end && pend_v_q) begin
      act_d    = pend_q;
      pend_v_d = 1'b0;
    end
    if (bus.load) begin
      pend_d   = '{num: bus.disp_num, pts: bus.points, en: bus.digit_en};
      pend_v_d = 1'b1;
    end
  end

`ifdef DISP_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] lzb_dark;
  logic                  hi_zero;
  always_comb begin
    lzb_dark = '0;
    hi_zero  = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      hi_zero     = hi_zero && (act_d.num[4*i +: 4] == 4'h0);
      lzb_dark[i] = hi_zero;
    end
    eff_en = act_d.en & ~lzb_dark;
  end
`else
  always_comb eff_en = act_d.en;
`endif

  // Outputs are computed from next-cycle state so the registered pins line up with cnt.
  always_comb begin
    show    = (state_d == SHOW) && eff_en[idx_next];
    an_d    = show ? an_sel(idx_next) : AN_OFF;
    le_d    = ~show;
    d_d     = act_d.num[{idx_next, 2'b00} +: 4];
    point_d = show && act_d.pts[idx_next];
    fd_d    = frame_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BLANK;
      act_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      an_q     <= AN_OFF;
      d_q      <= 4'h0;
      le_q     <= 1'b1;
      point_q  <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      an_q     <= an_d;
      d_q      <= d_d;
      le_q     <= le_d;
      point_q  <= point_d;
      fd_q     <= fd_d;
    end
  end

  assign bus.AN         = an_q;
  assign bus.D          = d_q;
  assign bus.LE         = le_q;
  assign bus.point      = point_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl: queued loads become the expected frame content at each boundary.
module tb_disp_scan_ctrl;
  localparam int SD = 8;
  localparam int BC = 2;

  typedef struct packed {
    logic [15:0] num;
    logic [3:0]  pts;
    logic [3:0]  en;
  } content_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  disp_scan_ctrl_if bus();

  disp_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  content_t sb[$];
  content_t act = '0;
  int       pos_c = 0, pos_i = 0;
  logic     fd_exp = 1'b0;
  int       n_assert = 0, n_fail = 0;
  string    phase = "init";

  function automatic logic [10:0] expect_out(content_t c, int cc, int ii, logic fd);
    logic       en, show;
    logic [3:0] an, d;
    en = c.en[ii];
`ifdef DISP_SCAN_LZB_EN
    if (ii > 0 && (c.num >> (4*ii)) == 16'h0) en = 1'b0;
`endif
    show = (cc >= BC) && en;
    an   = show ? ~(4'b0001 << ii) : 4'b1111;
    d    = c.num[4*ii +: 4];
    return {an, d, ~show, show & c.pts[ii], fd};
  endfunction

  task automatic check();
    logic [10:0] obs, exp;
    obs = {bus.AN, bus.D, bus.LE, bus.point, bus.frame_done};
    exp = expect_out(act, pos_c, pos_i, fd_exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s slot=%0d cnt=%0d observed AN_D_LE_pt_fd=%b_%h_%b_%b_%b expected %b_%h_%b_%b_%b",
             phase, pos_i, pos_c, obs[10:7], obs[6:3], obs[2], obs[1], obs[0],
             exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // One clock: advance the expected slot position, apply boundary/load/reset rules, compare.
  task automatic step();
    logic     wrap, ld, rs;
    content_t in_c;
    wrap = (pos_c == SD-1) && (pos_i == 3);
    ld   = bus.load;
    rs   = rst;
    in_c = {bus.disp_num, bus.points, bus.digit_en};
    @(posedge clk); #1;
    if (rs) begin
      pos_c = 0; pos_i = 0; act = '0; fd_exp = 1'b0;
      sb.delete();
    end else begin
      fd_exp = wrap;
      if (wrap && sb.size() > 0) begin
        act = sb.pop_back();
        sb.delete();
      end
      if (ld) sb.push_back(in_c);
      if (pos_c == SD-1) begin
        pos_c = 0;
        pos_i = (pos_i + 1) % 4;
      end else begin
        pos_c++;
      end
    end
    check();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_load(input logic [15:0] num, input logic [3:0] pts, input logic [3:0] en);
    bus.disp_num = num;
    bus.points   = pts;
    bus.digit_en = en;
    bus.load     = 1'b1;
    step();
    bus.load     = 1'b0;
  endtask

  task automatic wait_pos(input int c, input int i);
    int k = 0;
    while (!(pos_c == c && pos_i == i) && k < 64) begin
      step();
      k++;
    end
    if (!(pos_c == c && pos_i == i)) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s wait_pos timeout at slot=%0d cnt=%0d wanted slot=%0d cnt=%0d",
             phase, pos_i, pos_c, i, c);
    end
  endtask

  initial begin
    bus.disp_num = '0;
    bus.points   = '0;
    bus.digit_en = '0;
    bus.load     = 1'b0;

    phase = "reset";     rst = 1'b1; run(3); rst = 1'b0;
    phase = "dark";      run(4*SD);

    phase = "basic";     do_load(16'h1234, 4'b0001, 4'b1111); run(9*SD);
    phase = "digit_en";  do_load(16'h1234, 4'b0001, 4'b1010); run(9*SD);

    phase = "midframe";  wait_pos(3, 1);
    do_load(16'h9999, 4'b1111, 4'b1111);
    wait_pos(5, 2);
    do_load(16'hABCD, 4'b1000, 4'b1111);
    run(6*SD);

    phase = "wrap_load"; wait_pos(SD-1, 3);
    do_load(16'h5A3C, 4'b0010, 4'b1111);
    run(9*SD);

    phase = "rst_mid";   wait_pos(0, 2);
    do_load(16'hFFFF, 4'b1111, 4'b1111);
    wait_pos(5, 2);
    rst = 1'b1; step(); rst = 1'b0;
    phase = "after_rst"; run(5*SD);

    phase = "lzb";       do_load(16'h0050, 4'b0000, 4'b1111); run(9*SD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
